// File: rtl/int_ctrl18_pkg.sv
// int_ctrl18_pkg: shared Core18 constants for the interrupt controller.
package int_ctrl18_pkg;
  localparam int NIRQ = 15;
  localparam int VEC_W = 4;
  localparam logic [NIRQ-1:0] MODE_RST = 15'h7FFF;
  typedef enum logic [1:0] {
    OFS_MASK  = 2'd0,
    OFS_PEND  = 2'd1,
    OFS_MODE  = 2'd2,
    OFS_INSVC = 2'd3
  } reg_ofs_e;
endpackage

// File: rtl/int_ctrl18_prio_enc15.sv
// prio_enc15: returns the highest-numbered set request as a vector number 1..15, or 0.
module prio_enc15
  import int_ctrl18_pkg::*;
(
  input  logic [NIRQ-1:0]  req_i,
  output logic [VEC_W-1:0] vec_o
);
  always_comb begin
    vec_o = '0;
    for (int i = 0; i < NIRQ; i++)
      if (req_i[i]) vec_o = VEC_W'(i + 1);
  end
endmodule

// File: rtl/int_ctrl18.sv
// int_ctrl18: 15-line prioritised interrupt controller with port-mapped registers for Core18.
module int_ctrl18
  import int_ctrl18_pkg::*;
#(
  parameter logic [17:0] BASE_ADRS = 18'o777770,
  parameter int          BLANK     = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NIRQ-1:0]     IRQ,
  input  logic [11:0]         PC,
  input  logic                PORT_WR,
  input  logic                PORT_RD,
  input  logic [17:0]         ADRS,
  input  logic [17:0]         DATAOUT,
  output logic [VEC_W-1:0]    VECTOR,
  output logic [17:0]         PORT_DATA,
  output logic                IRQ_ANY
);
  localparam int CW = $clog2(BLANK + 2);
  logic [NIRQ-1:0]  mask_q, mask_d, pend_q, pend_d, mode_q, mode_d;
  logic [NIRQ-1:0]  sync_q, prev_q, prev_d, rise, w1c, acc_bit;
  logic [VEC_W-1:0] insvc_q, insvc_d, vec_q, vec_d, enc_vec;
  logic [CW-1:0]    blank_q, blank_d;
  logic             armed_q, sel, accept;
  logic [17:0]      ofs, rd_val;
  reg_ofs_e         ro;
  logic             unused_ok;

  assign unused_ok = ^DATAOUT[17:15];
  assign ofs = ADRS - BASE_ADRS;
  assign sel = ofs < 18'd4;
  assign ro  = reg_ofs_e'(ofs[1:0]);

  prio_enc15 u_enc (.req_i(pend_q & mask_q), .vec_o(enc_vec));

  always_comb begin
    // Until one cycle after reset the edge history tracks the raw lines, so lines already high never look like a rising edge.
    prev_d  = armed_q ? sync_q : IRQ;
    rise    = sync_q & ~prev_q;
    accept  = vec_q != '0 && PC == {8'b0, vec_q};
    acc_bit = accept ? (NIRQ'(1) << (vec_q - 4'd1)) : '0;
    w1c     = (PORT_WR && sel && ro == OFS_PEND) ? DATAOUT[NIRQ-1:0] : '0;
    mask_d  = (PORT_WR && sel && ro == OFS_MASK) ? DATAOUT[NIRQ-1:0] : mask_q;
    mode_d  = (PORT_WR && sel && ro == OFS_MODE) ? DATAOUT[NIRQ-1:0] : mode_q;
    pend_d  = (mode_q & ((pend_q & ~(w1c | acc_bit)) | rise)) | (~mode_q & sync_q);
    insvc_d = accept ? vec_q : insvc_q;
    blank_d = accept ? CW'(BLANK) : (blank_q != '0 ? blank_q - CW'(1) : '0);
    vec_d   = (accept || blank_d != '0) ? '0 : enc_vec;
    rd_val  = ro == OFS_MASK ? {3'b0, mask_q} :
              ro == OFS_PEND ? {3'b0, pend_q} :
              ro == OFS_MODE ? {3'b0, mode_q} : {14'b0, insvc_q};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mask_q  <= '0;
      pend_q  <= '0;
      mode_q  <= MODE_RST;
      insvc_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
      blank_q <= '0;
      vec_q   <= '0;
    end else begin
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      insvc_q <= insvc_d;
      sync_q  <= IRQ;
      prev_q  <= prev_d;
      armed_q <= 1'b1;
      blank_q <= blank_d;
      vec_q   <= vec_d;
    end
  end

  assign VECTOR    = vec_q;
  assign IRQ_ANY   = |(pend_q & mask_q);
  assign PORT_DATA = (PORT_RD && sel) ? rd_val : '0;
endmodule

// File: tb/tb_int_ctrl18.sv
// tb_int_ctrl18: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_int_ctrl18;
  localparam logic [17:0] BASE = 18'o777770;
  logic        CLK = 0, RESET_N = 0, PORT_WR = 0, PORT_RD = 0;
  logic [14:0] IRQ = '0;
  logic [11:0] PC = '0;
  logic [17:0] ADRS = '0, DATAOUT = '0;
  logic [3:0]  VECTOR;
  logic [17:0] PORT_DATA;
  logic        IRQ_ANY;
  int cyc = 0, n_chk = 0, n_fail = 0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [17:0] val;
    string       name;
  } chk_t;
  chk_t q[$];
  chk_t c_m;
  logic [17:0] act;

  int_ctrl18 dut (
    .CLK(CLK), .RESET_N(RESET_N), .IRQ(IRQ), .PC(PC), .PORT_WR(PORT_WR),
    .PORT_RD(PORT_RD), .ADRS(ADRS), .DATAOUT(DATAOUT), .VECTOR(VECTOR),
    .PORT_DATA(PORT_DATA), .IRQ_ANY(IRQ_ANY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // sig: 0 = VECTOR, 1 = PORT_DATA, 2 = IRQ_ANY; checked at the negedge of the current cycle
  task automatic want(input int sig, input logic [17:0] val, input string name);
    q.push_back('{cyc, sig, val, name});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [17:0] a, input logic [17:0] d);
    ADRS = a; DATAOUT = d; PORT_WR = 1;
    tick();
    PORT_WR = 0;
  endtask

  task automatic rd(input logic [17:0] a, input logic [17:0] v, input string name);
    ADRS = a; PORT_RD = 1;
    want(1, v, name);
    tick();
    PORT_RD = 0;
  endtask

  initial forever begin
    @(negedge CLK);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      c_m = q.pop_front();
      act = c_m.sig == 0 ? {14'b0, VECTOR} : c_m.sig == 1 ? PORT_DATA : {17'b0, IRQ_ANY};
      n_chk++;
      if (act !== c_m.val) begin
        n_fail++;
        $display("FAIL %s: got %0o, expected %0o (cycle %0d)", c_m.name, act, c_m.val, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick(2);
    want(0, 0, "rst_vector");
    want(2, 0, "rst_irq_any");
    rd(BASE, 0, "rst_mask");
    rd(BASE + 18'd1, 0, "rst_pend");
    rd(BASE + 18'd2, 18'h7FFF, "rst_mode");
    rd(BASE + 18'd3, 0, "rst_insvc");
    RESET_N = 1;
    tick();
    // single edge pulse, acceptance and blanking
    wr(BASE, 18'h7FFF);
    IRQ = 15'h0080; tick(); IRQ = 0;
    tick();
    want(0, 0, "t1_vec_pending");
    want(2, 1, "t1_irq_any");
    tick();
    want(0, 8, "t1_vec8");
    PC = 12'o10; tick(); PC = 0;
    want(0, 0, "t1_blank0");
    tick();
    want(0, 0, "t1_blank1");
    tick();
    want(0, 0, "t1_after_blank");
    rd(BASE + 18'd1, 0, "t1_pend_cleared");
    rd(BASE + 18'd3, 8, "t1_insvc");
    // two simultaneous edges, priority then the lower one
    IRQ = 15'h0204; tick(); IRQ = 0;
    tick(2);
    want(0, 10, "t2_vec10");
    PC = 12'o12; tick(); PC = 0;
    want(0, 0, "t2_blank");
    tick(2);
    want(0, 3, "t2_vec3");
    PC = 12'd3; tick(); PC = 0;
    tick(2);
    want(0, 0, "t2_idle");
    want(2, 0, "t2_irq_any_idle");
    // masked pending bit stays pending
    wr(BASE, 0);
    IRQ = 15'h0010; tick(); IRQ = 0;
    tick(2);
    want(0, 0, "t3_masked_vec");
    want(2, 0, "t3_masked_any");
    rd(BASE + 18'd1, 18'o20, "t3_pend");
    wr(BASE, 18'o20);
    want(0, 0, "t3_mask_lag");
    tick();
    want(0, 5, "t3_vec5");
    PC = 12'd5; tick(); PC = 0;
    wr(BASE, 18'h7FFF);
    tick(2);
    want(0, 0, "t3_done");
    // level mode on line 0
    wr(BASE + 18'd2, 18'h7FFE);
    IRQ = 15'h0001;
    tick(3);
    want(0, 1, "t4_vec1");
    PC = 12'd1; tick(); PC = 0;
    want(0, 0, "t4_blank");
    tick(2);
    want(0, 1, "t4_vec1_again");
    rd(BASE + 18'd3, 1, "t4_insvc");
    IRQ = 0;
    tick(2);
    want(0, 1, "t4_still1");
    tick();
    want(0, 0, "t4_dropped");
    wr(BASE + 18'd2, 18'h7FFF);
    // new edge collides with W1C of the same bit: set wins
    IRQ = 15'h0001; tick();
    wr(BASE + 18'd1, 18'o1);
    rd(BASE + 18'd1, 18'o1, "t5_pend_kept");
    want(0, 1, "t5_vec1");
    wr(BASE + 18'd1, 18'o1);
    tick();
    want(0, 0, "t5_w1c_cleared");
    // reset during blanking with a line held high
    IRQ = 15'h0009;
    tick(3);
    want(0, 4, "t6_vec4");
    PC = 12'd4; tick(); PC = 0;
    RESET_N = 0;
    tick();
    want(0, 0, "t6_rst_vec");
    want(2, 0, "t6_rst_any");
    rd(BASE, 0, "t6_rst_mask");
    rd(BASE + 18'd1, 0, "t6_rst_pend");
    rd(BASE + 18'd2, 18'h7FFF, "t6_rst_mode");
    rd(BASE + 18'd3, 0, "t6_rst_insvc");
    RESET_N = 1;
    tick();
    wr(BASE, 18'h7FFF);
    tick(3);
    want(0, 0, "t6_no_edge_vec");
    want(2, 0, "t6_no_edge_any");
    rd(BASE + 18'd1, 0, "t6_no_edge_pend");
    // out-of-range accesses
    wr(BASE - 18'd1, 0);
    wr(BASE + 18'd4, 0);
    rd(BASE, 18'h7FFF, "t7_mask_kept");
    rd(BASE + 18'd4, 0, "t7_oob_read");
    ADRS = BASE; PORT_RD = 0;
    want(1, 0, "t7_no_rd_strobe");
    tick();
    IRQ = 0;
    tick(3);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked, expected 0", q.size());
      n_fail += q.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
